fir_frame_collector: RTL and testbench
======================================

FIR_FRAME_COLLECTOR -- requirements
Module: fir_frame_collector

Interface
REQ-001 Parameter FRAME_LEN, default 16, SHALL set the samples per frame; legal values are powers of two from 2 to 64.
REQ-002 Parameter DW, default 16, SHALL set the sample width in bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-005 Port fir_valid, input, 1, SHALL qualify fir_d; there is no backpressure, so a sample is offered on every cycle it is high.
REQ-006 Port fir_d, input, DW, SHALL carry the signed filter output sample.
REQ-007 Port frame_valid, output, 1, SHALL indicate that a complete frame is presented.
REQ-008 Port frame_ready, input, 1, SHALL indicate that the downstream FFT accepts the frame.
REQ-009 Port frame_data, output, FRAME_LEN*DW, SHALL carry the frame; sample k is at bits [k*DW +: DW], with k=0 the oldest sample.
REQ-010 Port overflow, output, 1, SHALL pulse for one cycle for each dropped sample.

Function
REQ-011 The block SHALL hold two banks (ping-pong) of FRAME_LEN samples each, with a write-bank pointer, a read-bank pointer, a write index and a full flag per bank.
REQ-012 A sample SHALL be accepted when fir_valid=1 and the write bank is not full: it is stored at the write index, and the index increments.
REQ-013 When the sample at index FRAME_LEN-1 is accepted, the block SHALL:
- set that bank's full flag;
- wrap the index to 0;
- toggle the write-bank pointer.
REQ-014 When fir_valid=1 and the write bank is full (both banks full), the sample SHALL be dropped, overflow SHALL be 1 in the following cycle, and stored data SHALL be unchanged.
REQ-015 frame_valid SHALL equal the full flag of the read bank; it asserts the cycle after the final sample of a frame is accepted.
REQ-016 frame_data SHALL reflect the read bank contents and SHALL stay stable while frame_valid=1 and frame_ready=0.
REQ-017 On frame_valid & frame_ready, the block SHALL clear the read bank's full flag and toggle the read-bank pointer.
REQ-018 When a write-bank completion and a read-bank release occur in the same cycle, both SHALL take effect.
REQ-019 With both banks full, a release SHALL make the freed bank writable on the next cycle; a sample arriving in the release cycle is dropped.
REQ-020 Back-to-back frames with frame_ready held high SHALL sustain 100% input rate with no drops.
REQ-021 frame_ready while frame_valid=0 SHALL have no effect.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL:
- clear both full flags;
- set both pointers to bank 0;
- set the write index to 0;
- drive frame_valid=0 and overflow=0.
REQ-023 Sample storage SHALL NOT require reset, but frame_data SHALL be all zeros while frame_valid=0.
REQ-024 Reset mid-frame SHALL discard the partial frame and any pending full frames; fir_valid during reset SHALL be ignored.

Configuration
REQ-025 Macro FIR_FRAME_DROP_CNT_EN defined: the block SHALL add output drop_cnt[7:0], which counts dropped samples, saturates at 255 and clears on reset.
REQ-026 Macro FIR_FRAME_DROP_CNT_EN undefined: the drop_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package fir_frame_pkg SHALL hold:
- the FRAME_LEN and DW defaults;
- the bank-select type (1 bit);
- the index width constant $clog2(FRAME_LEN).
REQ-028 Sub-module fir_frame_bank SHALL implement one bank (write enable, write index, write data, flat read-out); it is instantiated twice.

Verification
REQ-029 Bench SHALL cover: after reset, 16 samples 0x0001..0x0010 on consecutive cycles with frame_ready=0 -> frame_valid=1 on the next cycle, frame_data[15:0]=0x0001, frame_data[255:240]=0x0010.
REQ-030 Bench SHALL cover: frame_ready=0 while 32 samples arrive, then 1 more -> overflow pulses once, both frames intact, and drop_cnt=1 when FIR_FRAME_DROP_CNT_EN is defined.
REQ-031 Bench SHALL cover: frame_ready=1 with 64 continuous samples -> 4 frames delivered, no overflow, each frame starting at samples 0, 16, 32 and 48.
REQ-032 Bench SHALL cover: frame completion coinciding with the release of the other bank -> no drop, and frame_valid stays 1 with the new bank's data.
REQ-033 Bench SHALL cover: rst asserted after 7 samples, then 16 samples 0x0100..0x010F -> the first frame holds 0x0100 at k=0.
REQ-034 Bench SHALL cover: 300 drops with the macro defined -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/fir_frame_pkg.sv
// Shared types and defaults for the FIR ping-pong frame collector.
package fir_frame_pkg;
  localparam int FRAME_LEN_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int IDX_W = $clog2(FRAME_LEN_DEF);

  typedef logic bank_sel_t;
endpackage

// File: rtl/fir_frame_bank.sv
// One sample bank: indexed write port, flat read-out (k=0 oldest).
module fir_frame_bank
  import fir_frame_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = $clog2(FRAME_LEN)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IW-1:0]           widx,
  input  logic [DW-1:0]           wdata,
  output logic [FRAME_LEN*DW-1:0] rdata
);
  logic [DW-1:0] mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      rdata[k*DW +: DW] = mem[k];
    end
  end
endmodule

// File: rtl/fir_frame_collector.sv
// Ping-pong collector of FIR samples into FFT frames.
// Define FIR_FRAME_DROP_CNT_EN to add the saturating drop_cnt output.
module fir_frame_collector
  import fir_frame_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fir_valid,
  input  logic [DW-1:0]           fir_d,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [FRAME_LEN*DW-1:0] frame_data,
  output logic                    overflow
`ifdef FIR_FRAME_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);
  localparam int IW = $clog2(FRAME_LEN);

  bank_sel_t wr_bank;
  bank_sel_t rd_bank;
  logic [IW-1:0] widx;
  logic [1:0] full;
  logic [1:0] full_n;
  logic [1:0] we;
  logic accept;
  logic drop;
  logic last;
  logic rel;
  logic [FRAME_LEN*DW-1:0] rdata [2];

  assign accept = fir_valid & ~full[wr_bank];
  assign drop   = fir_valid & full[wr_bank];
  assign last   = accept & (widx == IW'(FRAME_LEN-1));
  assign rel    = full[rd_bank] & frame_ready;
  assign we[0]  = accept & ~wr_bank;
  assign we[1]  = accept & wr_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fir_frame_bank #(
      .FRAME_LEN(FRAME_LEN),
      .DW(DW)
    ) u_bank (
      .clk(clk),
      .we(we[b]),
      .widx(widx),
      .wdata(fir_d),
      .rdata(rdata[b])
    );
  end

  assign frame_valid = full[rd_bank];
  assign frame_data  = frame_valid ? rdata[rd_bank] : '0;

  // completion and release always hit different banks
  always_comb begin
    full_n = full;
    if (last) full_n[wr_bank] = 1'b1;
    if (rel)  full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      widx     <= '0;
      full     <= '0;
      overflow <= 1'b0;
    end else begin
      full     <= full_n;
      overflow <= drop;
      if (accept) widx <= widx + 1'b1;
      if (last)   wr_bank <= ~wr_bank;
      if (rel)    rd_bank <= ~rd_bank;
    end
  end

`ifdef FIR_FRAME_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fir_frame_collector.sv
// Bench for fir_frame_collector: directed table, corner sequences
// and random traffic against a queue-based frame model.
module tb_fir_frame_collector;
  localparam int FL = 16;
  localparam int DW = 16;
  localparam int FW = FL*DW;

  logic clk;
  logic rst;
  logic fir_valid;
  logic [DW-1:0] fir_d;
  logic frame_valid;
  logic frame_ready;
  logic [FW-1:0] frame_data;
  logic overflow;
`ifdef FIR_FRAME_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  fir_frame_collector #(.FRAME_LEN(FL), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .fir_valid(fir_valid),
    .fir_d(fir_d),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data(frame_data),
    .overflow(overflow)
`ifdef FIR_FRAME_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model: complete frames awaiting release, plus the frame being filled
  logic [FW-1:0] pq[$];
  logic [DW-1:0] part[$];
  logic m_ovf = 1'b0;
  int m_cnt = 0;
  int ovf_seen = 0;
  logic [DW-1:0] delivered[$];

  typedef struct {
    logic v;
    logic [DW-1:0] d;
    logic r;
    logic rs;
    logic fv;
    logic ovf;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic r, input logic rs);
    logic pre_fv;
    logic [DW-1:0] pre_d0;
    logic [FW-1:0] fr;
    logic rel;
    @(negedge clk);
    pre_fv = frame_valid;
    pre_d0 = frame_data[DW-1:0];
    fir_valid = v;
    fir_d = d;
    frame_ready = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      pq.delete();
      part.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      if (pre_fv && r) delivered.push_back(pre_d0);
      rel = (pq.size() > 0) && r;
      m_ovf = 1'b0;
      if (v) begin
        if (pq.size() == 2) begin
          m_ovf = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          part.push_back(d);
          if (part.size() == FL) begin
            fr = '0;
            for (int k = 0; k < FL; k++) fr[k*DW +: DW] = part[k];
            pq.push_back(fr);
            part.delete();
          end
        end
      end
      if (rel) void'(pq.pop_front());
    end
    #1;
    if (overflow === 1'b1) ovf_seen++;
    chk("frame_valid", frame_valid, pq.size() > 0);
    chk("frame_data", frame_data, pq.size() > 0 ? pq[0] : '0);
    chk("overflow", overflow, m_ovf);
`ifdef FIR_FRAME_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, m_cnt);
`endif
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base,
                      input logic r);
    for (int i = 0; i < n; i++) step(1'b1, base + DW'(i), r, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    fir_valid = 1'b0;
    fir_d = '0;
    frame_ready = 1'b0;

    // first frame after reset, table-driven
    tbl[0] = '{v: 1'b0, d: '0, r: 1'b0, rs: 1'b1, fv: 1'b0, ovf: 1'b0};
    for (int i = 1; i <= 16; i++) begin
      tbl[i] = '{v: 1'b1, d: DW'(i), r: 1'b0, rs: 1'b0,
                 fv: (i == 16), ovf: 1'b0};
    end
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].rs);
      chk("tbl_fv", frame_valid, tbl[i].fv);
      chk("tbl_ovf", overflow, tbl[i].ovf);
    end
    chk("first_k0", frame_data[15:0], 16'h0001);
    chk("first_k15", frame_data[255:240], 16'h0010);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("release_fv", frame_valid, 1'b0);
    chk("release_zero", frame_data, '0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("idle_ready_fv", frame_valid, 1'b0);

    // both banks full, one more sample dropped
    step(1'b0, '0, 1'b0, 1'b1);
    ovf_seen = 0;
    fill(32, 16'h0200, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("drop_ovf", overflow, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("drop_ovf_clear", overflow, 1'b0);
    chk("drop_once", ovf_seen, 1);
    chk("drop_k0", frame_data[15:0], 16'h0200);
    chk("drop_k15", frame_data[255:240], 16'h020F);
`ifdef FIR_FRAME_DROP_CNT_EN
    chk("drop_cnt1", drop_cnt, 8'd1);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    chk("second_k0", frame_data[15:0], 16'h0210);
    chk("second_k15", frame_data[255:240], 16'h021F);

    // streaming with ready held high
    step(1'b0, '0, 1'b1, 1'b1);
    ovf_seen = 0;
    delivered.delete();
    fill(64, 16'h0000, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_frames", delivered.size(), 4);
    chk("stream_ovf", ovf_seen, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < delivered.size()) chk("stream_start", delivered[i], i*16);
    end

    // completion in the same cycle as release of the other bank
    step(1'b0, '0, 1'b0, 1'b1);
    fill(16, 16'h0300, 1'b0);
    fill(15, 16'h0400, 1'b0);
    step(1'b1, 16'h040F, 1'b1, 1'b0);
    chk("swap_fv", frame_valid, 1'b1);
    chk("swap_k0", frame_data[15:0], 16'h0400);
    chk("swap_ovf", overflow, 1'b0);

    // reset mid-frame discards the partial frame
    step(1'b0, '0, 1'b0, 1'b1);
    fill(7, 16'h0050, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    chk("rst_fv", frame_valid, 1'b0);
    fill(16, 16'h0100, 1'b0);
    chk("rst_frame_fv", frame_valid, 1'b1);
    chk("rst_frame_k0", frame_data[15:0], 16'h0100);

`ifdef FIR_FRAME_DROP_CNT_EN
    step(1'b0, '0, 1'b0, 1'b1);
    fill(32, 16'h0600, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 16'h0700, 1'b0, 1'b0);
    chk("drop_sat", drop_cnt, 8'd255);
`endif

    // random traffic
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 80, DW'($urandom),
           $urandom_range(0, 99) < 30, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
